// File: rtl/esc_pkg.sv
// esc_pkg: shared types and elaboration-time helpers for the ESC PWM array.
package esc_pkg;

  typedef enum logic {
    ARMING = 1'b0,
    RUN    = 1'b1
  } esc_state_t;

  // Pulse width in clocks for a given speed command.
  function automatic int unsigned pulse_width(input int unsigned spd,
                                              input int unsigned min_pulse,
                                              input int unsigned scale);
    return min_pulse + spd * scale;
  endfunction

  // True when the widest possible pulse still fits inside one period.
  function automatic bit width_fits(input int spd_w, input int period_w,
                                    input int min_pulse, input int scale);
    longint max_w;
    max_w = longint'(min_pulse) + ((longint'(1) << spd_w) - 1) * longint'(scale);
    return max_w < (longint'(1) << period_w);
  endfunction

endpackage

// File: rtl/esc_array_if.sv
// esc_array_if: speed command / PWM bundle between flight controller and ESC array.
interface esc_array_if #(
  parameter int NUM_CH = 4,
  parameter int SPD_W  = 11
);
  logic [NUM_CH*SPD_W-1:0] spd;
  logic                    wrt;
  logic                    motors_off;
  logic [NUM_CH-1:0]       pwm;
  logic                    armed;
  logic                    period_start;

  modport master (output spd, wrt, motors_off, input pwm, armed, period_start);
  modport slave  (input spd, wrt, motors_off, output pwm, armed, period_start);
endinterface

// File: rtl/esc_chan.sv
// esc_chan: one motor channel -- shadow/active speed, optional slew step, width compare.
// Build option: SLEW_LIMIT_EN limits each period-boundary speed change to MAX_STEP.
module esc_chan
  import esc_pkg::*;
#(
  parameter int SPD_W     = 11,
  parameter int PERIOD_W  = 20,
  parameter int MIN_PULSE = 6250,
`ifdef SLEW_LIMIT_EN
  parameter int MAX_STEP  = 16,
`endif
  parameter int SCALE     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SPD_W-1:0]    spd_in,
  input  logic                wrt,
  input  logic                load,
  input  logic                zero_tgt,
  input  logic [PERIOD_W-1:0] cnt,
  output logic                pwm
);

  logic [SPD_W-1:0]    shadow_q;
  logic [SPD_W-1:0]    active_q;
  logic [SPD_W-1:0]    target;
  logic [SPD_W-1:0]    next_act;
  logic [PERIOD_W-1:0] width;

  // A write landing on the load cycle goes straight to the active register.
  assign target = (wrt && load) ? spd_in : shadow_q;
  assign width  = PERIOD_W'(pulse_width(32'(active_q), MIN_PULSE, SCALE));

  // Next active speed: direct, or stepped toward the target when slew limiting is built in.
  always_comb begin
    next_act = target;
`ifdef SLEW_LIMIT_EN
    if (int'(target) > int'(active_q) + MAX_STEP)
      next_act = active_q + SPD_W'(MAX_STEP);
    else if (int'(target) + MAX_STEP < int'(active_q))
      next_act = active_q - SPD_W'(MAX_STEP);
`endif
  end

  // Shadow capture, period-boundary active load (forced zero bypasses slew), pwm flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm      <= 1'b0;
    end else begin
      if (wrt)
        shadow_q <= spd_in;
      if (load)
        active_q <= zero_tgt ? '0 : next_act;
      pwm <= (cnt < width);
    end
  end

endmodule

// File: rtl/esc_array.sv
// esc_array: N-channel servo-style ESC PWM driver with arming sequence.
// Build option: SLEW_LIMIT_EN enables per-period slew limiting in each channel.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   ARMING | all channels forced to MIN_PULSE; counts ARM_PERIODS loads
//   RUN    | channels follow shadowed speed commands; left only by reset
module esc_array
  import esc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SPD_W       = 11,
  parameter int PERIOD_W    = 20,
  parameter int MIN_PULSE   = 6250,
  parameter int SCALE       = 3,
  parameter int ARM_PERIODS = 64,
  parameter int MAX_STEP    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  esc_array_if.slave  bus
);

  localparam int ARM_W = (ARM_PERIODS > 1) ? $clog2(ARM_PERIODS) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_PERIODS - 1);

  if (!width_fits(SPD_W, PERIOD_W, MIN_PULSE, SCALE)) begin : g_width_check
    $error("esc_array: MIN_PULSE + max speed * SCALE does not fit in the period");
  end
  if (ARM_PERIODS < 1 || MAX_STEP < 0) begin : g_param_check
    $error("esc_array: ARM_PERIODS must be >= 1 and MAX_STEP >= 0");
  end

  logic [PERIOD_W-1:0] cnt_q;
  logic                load;
  logic                ps_q;
  esc_state_t          state_q, state_d;
  logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d;
  logic                arm_done;
  logic                zero_tgt;
  logic [NUM_CH-1:0]   pwm_w;

  assign load = (cnt_q == '1);
  // The final arming load already uses the shadow so the first RUN period carries commands.
  assign zero_tgt = bus.motors_off || !((state_q == RUN) || arm_done);

  // Free-running period counter and registered period_start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + PERIOD_W'(1);
      ps_q  <= (cnt_q == '0);
    end
  end

  // FSM state and arming period count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARMING;
      arm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  // Next state: advance arming count at each load, enter RUN on the last one.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    arm_done  = 1'b0;
    case (state_q)
      ARMING: begin
        if (load) begin
          if (arm_cnt_q == ARM_LAST) begin
            state_d  = RUN;
            arm_done = 1'b1;
          end else begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
          end
        end
      end
      RUN: state_d = RUN;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    esc_chan #(
      .SPD_W     (SPD_W),
      .PERIOD_W  (PERIOD_W),
      .MIN_PULSE (MIN_PULSE),
`ifdef SLEW_LIMIT_EN
      .MAX_STEP  (MAX_STEP),
`endif
      .SCALE     (SCALE)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .spd_in   (bus.spd[g*SPD_W +: SPD_W]),
      .wrt      (bus.wrt),
      .load     (load),
      .zero_tgt (zero_tgt),
      .cnt      (cnt_q),
      .pwm      (pwm_w[g])
    );
  end

  assign bus.pwm          = pwm_w;
  assign bus.armed        = (state_q == RUN);
  assign bus.period_start = ps_q;

endmodule

// File: tb/tb_esc_array.sv
// tb_esc_array: directed period-by-period checks of pulse widths, arming and reset.
module tb_esc_array;

  localparam int NUM_CH = 4;
  localparam int SPD_W  = 4;
  localparam int PER    = 256;

  localparam int K_NONE   = 0;
  localparam int K_WRT    = 1;
  localparam int K_MOFF_1 = 2;
  localparam int K_MOFF_0 = 3;

  typedef struct {
    int               a_cnt;
    int               a_kind;
    logic [15:0]      a_spd;
    int               a2_cnt;
    logic [15:0]      a2_spd;
    logic [3:0][7:0]  exp_w;
    logic             exp_armed;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   meas[NUM_CH];
  logic armed_at_start;
  vec_t vt[$];

  esc_array_if #(.NUM_CH(NUM_CH), .SPD_W(SPD_W)) bus ();

  esc_array #(
    .NUM_CH(NUM_CH), .SPD_W(SPD_W), .PERIOD_W(8), .MIN_PULSE(10),
    .SCALE(2), .ARM_PERIODS(2), .MAX_STEP(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a_cnt, input int a_kind, input logic [15:0] a_spd,
                              input int a2_cnt, input logic [15:0] a2_spd,
                              input logic [3:0][7:0] exp_w, input logic exp_armed);
    vec_t v;
    v.a_cnt = a_cnt; v.a_kind = a_kind; v.a_spd = a_spd;
    v.a2_cnt = a2_cnt; v.a2_spd = a2_spd;
    v.exp_w = exp_w; v.exp_armed = exp_armed;
    return v;
  endfunction

  // Finds the next period_start, then counts pwm highs over one period while
  // applying the requested stimulus in the cycle where the counter equals a_cnt.
  task automatic run_period(input int a_cnt, input int a_kind, input logic [15:0] a_spd,
                            input int a2_cnt, input logic [15:0] a2_spd);
    bit found = 1'b0;
    for (int k = 0; k < 3 * PER && !found; k++) begin
      @(negedge clk);
      bus.wrt = 1'b0;
      if (bus.period_start) found = 1'b1;
    end
    check("period_start seen", int'(found), 1);
    armed_at_start = bus.armed;
    for (int i = 0; i < NUM_CH; i++) meas[i] = 0;
    if (!found) return;
    for (int j = 0; j < PER; j++) begin
      if (j > 0) begin
        @(negedge clk);
        bus.wrt = 1'b0;
      end
      if (a_kind != K_NONE && ((j + 1) % PER) == a_cnt) begin
        case (a_kind)
          K_WRT:    begin bus.spd = a_spd; bus.wrt = 1'b1; end
          K_MOFF_1: bus.motors_off = 1'b1;
          K_MOFF_0: bus.motors_off = 1'b0;
          default:  ;
        endcase
      end
      if (a2_cnt != 0 && ((j + 1) % PER) == a2_cnt) begin
        bus.spd = a2_spd;
        bus.wrt = 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++)
        if (bus.pwm[i]) meas[i]++;
    end
  endtask

  initial begin
`ifdef SLEW_LIMIT_EN
    vt.push_back(mk(0,   K_NONE,   16'h0000, 0, 16'h0, {8'd10, 8'd10, 8'd10, 8'd10}, 1'b0));
    vt.push_back(mk(0,   K_NONE,   16'h0000, 0, 16'h0, {8'd10, 8'd10, 8'd10, 8'd10}, 1'b0));
    vt.push_back(mk(40,  K_WRT,    16'hFFFF, 0, 16'h0, {8'd10, 8'd10, 8'd10, 8'd10}, 1'b1));
    vt.push_back(mk(0,   K_NONE,   16'h0000, 0, 16'h0, {8'd16, 8'd16, 8'd16, 8'd16}, 1'b1));
    vt.push_back(mk(0,   K_NONE,   16'h0000, 0, 16'h0, {8'd22, 8'd22, 8'd22, 8'd22}, 1'b1));
    vt.push_back(mk(0,   K_NONE,   16'h0000, 0, 16'h0, {8'd28, 8'd28, 8'd28, 8'd28}, 1'b1));
    vt.push_back(mk(0,   K_NONE,   16'h0000, 0, 16'h0, {8'd34, 8'd34, 8'd34, 8'd34}, 1'b1));
    vt.push_back(mk(50,  K_MOFF_1, 16'h0000, 0, 16'h0, {8'd40, 8'd40, 8'd40, 8'd40}, 1'b1));
    vt.push_back(mk(50,  K_MOFF_0, 16'h0000, 0, 16'h0, {8'd10, 8'd10, 8'd10, 8'd10}, 1'b1));
    vt.push_back(mk(60,  K_WRT,    16'h0000, 0, 16'h0, {8'd16, 8'd16, 8'd16, 8'd16}, 1'b1));
    vt.push_back(mk(0,   K_NONE,   16'h0000, 0, 16'h0, {8'd10, 8'd10, 8'd10, 8'd10}, 1'b1));
`else
    vt.push_back(mk(5,   K_WRT,    16'hFFFF, 0,   16'h0,    {8'd10, 8'd10, 8'd10, 8'd10}, 1'b0));
    vt.push_back(mk(0,   K_NONE,   16'h0000, 0,   16'h0,    {8'd10, 8'd10, 8'd10, 8'd10}, 1'b0));
    vt.push_back(mk(0,   K_NONE,   16'h0000, 0,   16'h0,    {8'd40, 8'd40, 8'd40, 8'd40}, 1'b1));
    vt.push_back(mk(100, K_WRT,    16'hFFF5, 0,   16'h0,    {8'd40, 8'd40, 8'd40, 8'd40}, 1'b1));
    vt.push_back(mk(0,   K_NONE,   16'h0000, 0,   16'h0,    {8'd40, 8'd40, 8'd40, 8'd20}, 1'b1));
    vt.push_back(mk(255, K_WRT,    16'hFF75, 0,   16'h0,    {8'd40, 8'd40, 8'd40, 8'd20}, 1'b1));
    vt.push_back(mk(0,   K_NONE,   16'h0000, 0,   16'h0,    {8'd40, 8'd40, 8'd24, 8'd20}, 1'b1));
    vt.push_back(mk(0,   K_NONE,   16'h0000, 0,   16'h0,    {8'd40, 8'd40, 8'd24, 8'd20}, 1'b1));
    vt.push_back(mk(10,  K_WRT,    16'hFFFF, 0,   16'h0,    {8'd40, 8'd40, 8'd24, 8'd20}, 1'b1));
    vt.push_back(mk(50,  K_MOFF_1, 16'h0000, 0,   16'h0,    {8'd40, 8'd40, 8'd40, 8'd40}, 1'b1));
    vt.push_back(mk(50,  K_MOFF_0, 16'h0000, 0,   16'h0,    {8'd10, 8'd10, 8'd10, 8'd10}, 1'b1));
    vt.push_back(mk(0,   K_NONE,   16'h0000, 0,   16'h0,    {8'd40, 8'd40, 8'd40, 8'd40}, 1'b1));
    vt.push_back(mk(20,  K_WRT,    16'h0000, 200, 16'h1234, {8'd40, 8'd40, 8'd40, 8'd40}, 1'b1));
    vt.push_back(mk(0,   K_NONE,   16'h0000, 0,   16'h0,    {8'd12, 8'd14, 8'd16, 8'd18}, 1'b1));
`endif

    rst_n = 1'b0;
    bus.spd = '0;
    bus.wrt = 1'b0;
    bus.motors_off = 1'b0;
    repeat (3) @(negedge clk);
    check("reset pwm", int'(bus.pwm), 0);
    check("reset armed", int'(bus.armed), 0);
    check("reset period_start", int'(bus.period_start), 0);
    rst_n = 1'b1;

    for (int r = 0; r < vt.size(); r++) begin
      run_period(vt[r].a_cnt, vt[r].a_kind, vt[r].a_spd, vt[r].a2_cnt, vt[r].a2_spd);
      check($sformatf("row%0d armed", r), int'(armed_at_start), int'(vt[r].exp_armed));
      for (int i = 0; i < NUM_CH; i++)
        check($sformatf("row%0d ch%0d width", r, i), meas[i], int'(vt[r].exp_w[i]));
    end

    // Reset in the middle of a pulse: pwm and armed drop at once, arming restarts.
    begin
      bit found = 1'b0;
      for (int k = 0; k < 3 * PER && !found; k++) begin
        @(negedge clk);
        if (bus.period_start) found = 1'b1;
      end
      check("pre-reset period_start seen", int'(found), 1);
      repeat (4) @(negedge clk);
      check("pre-reset pwm high", int'(bus.pwm), 15);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid-period reset pwm", int'(bus.pwm), 0);
      check("mid-period reset armed", int'(bus.armed), 0);
      check("mid-period reset period_start", int'(bus.period_start), 0);
      rst_n = 1'b1;
      for (int p = 0; p < 3; p++) begin
        run_period(0, K_NONE, 16'h0, 0, 16'h0);
        check($sformatf("rearm p%0d armed", p), int'(armed_at_start), (p == 2) ? 1 : 0);
        for (int i = 0; i < NUM_CH; i++)
          check($sformatf("rearm p%0d ch%0d width", p, i), meas[i], 10);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
